// File: rtl/alu_result_checker_if.sv
// Vector/result handshake between the ALU stimulus side and the result checker.
interface alu_result_checker_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_i0;
  logic [W-1:0] in_i1;
  logic [W-1:0] in_o;
  logic         in_cout;

  modport master (
    output in_valid, in_op, in_i0, in_i1, in_o, in_cout,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_i0, in_i1, in_o, in_cout,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// ALU result checker: recomputes {cout, o} per vector, counts pass/fail, captures the first miss.
// Optional ALU_CHK_HALT_ON_FAIL_EN: first mismatch ends the run early via DRAIN.
module alu_result_checker #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  alu_result_checker_if.slave vec,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [W:0]       first_fail_exp,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] nv_q;
  logic [CNT_W-1:0] acc_cnt;

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [W-1:0]     s1_i0, s1_i1, s1_o;
  logic             s1_cout;
  logic [CNT_W-1:0] s1_idx;
  logic             s2_valid;

  logic             xfer, launch, last_xfer;
  logic [W:0]       s2_exp;
  logic             s2_match, s2_fail;

  // Stage 2: expected result from the stage-1 vector, compared against the observed one
  always_comb begin
    s2_exp = '0;
    case (s1_op)
      2'b00:   s2_exp = {1'b0, s1_i0} + {1'b0, s1_i1};
      2'b01:   s2_exp = {1'b0, s1_i0} + {1'b0, ~s1_i1} + (W+1)'(1);
      2'b10:   s2_exp = {1'b0, s1_i0 & s1_i1};
      default: s2_exp = {1'b0, s1_i0 | s1_i1};
    endcase
    s2_match = ({s1_cout, s1_o} == s2_exp);
    s2_fail  = s1_valid && !s2_match;
  end

  always_comb begin
    xfer      = vec.in_valid && vec.in_ready;
    launch    = start && ((state == IDLE) || (state == DONE));
    last_xfer = xfer && ((acc_cnt + CNT_W'(1)) == nv_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    vec.in_ready = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        vec.in_ready = 1'b1;
        if (last_xfer) state_nx = DRAIN;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
        if (s2_fail) state_nx = DRAIN;
`endif
      end
      DRAIN: if (!s1_valid && !s2_valid) state_nx = DONE;
      DONE:  if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
    pass = done && (fail_cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nv_q           <= '0;
      acc_cnt        <= '0;
      s1_valid       <= 1'b0;
      s1_op          <= '0;
      s1_i0          <= '0;
      s1_i1          <= '0;
      s1_o           <= '0;
      s1_cout        <= 1'b0;
      s1_idx         <= '0;
      s2_valid       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
    end else begin
      s1_valid <= xfer;
      s2_valid <= s1_valid;
      if (xfer) begin
        s1_op   <= vec.in_op;
        s1_i0   <= vec.in_i0;
        s1_i1   <= vec.in_i1;
        s1_o    <= vec.in_o;
        s1_cout <= vec.in_cout;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      // launch only happens with an empty pipeline, so it never collides with a stage-2 update
      if (launch) begin
        nv_q           <= (num_vecs == '0) ? CNT_W'(1) : num_vecs;
        acc_cnt        <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
      end else if (s2_fail) begin
        if (fail_cnt == '0) begin
          first_fail_idx <= s1_idx;
          first_fail_exp <= s2_exp;
        end
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      end else if (s1_valid) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized self-checking bench for alu_result_checker against an arithmetic reference model.
module tb_alu_result_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_vecs;
  logic [7:0]  pass_cnt, fail_cnt, first_fail_idx;
  logic [16:0] first_fail_exp;
  logic        busy, done, pass;

  int total;
  int bad;

  alu_result_checker_if #(.W(16)) vif ();

  alu_result_checker #(.W(16), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start          (start),
    .num_vecs       (num_vecs),
    .vec            (vif),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_exp (first_fail_exp),
    .busy           (busy),
    .done           (done),
    .pass           (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  q_op[$];
  logic [15:0] q_i0[$], q_i1[$], q_o[$];
  logic        q_c[$];

  int          m_pass, m_fail, m_idx, m_acc;
  logic [16:0] m_exp;

  // Reference result computed as plain integer arithmetic on the operand values
  function automatic logic [16:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    int unsigned x, y, r;
    x = {16'd0, a};
    y = {16'd0, b};
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x + 32'd65536 - y;
      2'd2:    r = x & y;
      default: r = x | y;
    endcase
    return r[16:0];
  endfunction

  task automatic clear_q();
    q_op.delete(); q_i0.delete(); q_i1.delete(); q_o.delete(); q_c.delete();
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] o, input logic c);
    q_op.push_back(op); q_i0.push_back(a); q_i1.push_back(b); q_o.push_back(o); q_c.push_back(c);
  endtask

  task automatic rand_vec(input bit allow_err, output logic [1:0] op, output logic [15:0] a,
                          output logic [15:0] b, output logic [16:0] r);
    int k;
    op = 2'($urandom_range(0, 3));
    a  = ($urandom_range(0, 5) == 0) ? 16'hffff : 16'($urandom);
    b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
    r  = ref_result(op, a, b);
    if (allow_err && $urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, 16);
      r[k] = ~r[k];
    end
  endtask

  // Drives one run from the queues, following the handshake, and scores accepted vectors
  task automatic drive_run(input logic [7:0] nv, input bit gaps);
    int          t;
    bit          acc, ended;
    logic [16:0] e;
    m_pass = 0; m_fail = 0; m_idx = 0; m_exp = '0; m_acc = 0; ended = 0;
    start = 1'b1; num_vecs = nv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < q_op.size() && !ended; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        vif.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      vif.in_valid = 1'b1;
      vif.in_op = q_op[i]; vif.in_i0 = q_i0[i]; vif.in_i1 = q_i1[i];
      vif.in_o  = q_o[i];  vif.in_cout = q_c[i];
      acc = 0; t = 0;
      while (!acc && !ended) begin
        @(negedge clk);
        acc = vif.in_ready;
        @(posedge clk); #1;
        if (acc) begin
          e = ref_result(q_op[i], q_i0[i], q_i1[i]);
          if ({q_c[i], q_o[i]} == e) begin
            if (m_pass < 255) m_pass++;
          end else begin
            if (m_fail == 0) begin m_idx = m_acc; m_exp = e; end
            if (m_fail < 255) m_fail++;
          end
          m_acc++;
        end else if (!busy) begin
          ended = 1;
        end
        t++;
        if (t > 60) begin
          total++; bad++;
          $display("FAIL accept_timeout got=in_ready_low exp=accept_within_60");
          ended = 1;
        end
      end
    end
    vif.in_valid = 1'b0;
    t = 0;
    while (!done && t < 100) begin @(posedge clk); #1; t++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_timeout got=%b exp=1", done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pass_cnt !== 8'd0) begin bad++; $display("FAIL rst_pass_cnt got=%0d exp=0", pass_cnt); end
    total++; if (fail_cnt !== 8'd0) begin bad++; $display("FAIL rst_fail_cnt got=%0d exp=0", fail_cnt); end
    total++; if (first_fail_idx !== 8'd0) begin bad++; $display("FAIL rst_ff_idx got=%0d exp=0", first_fail_idx); end
    total++; if (first_fail_exp !== 17'd0) begin bad++; $display("FAIL rst_ff_exp got=%h exp=0", first_fail_exp); end
    total++; if ({busy, done, pass, vif.in_ready} !== 4'b0000) begin
      bad++; $display("FAIL rst_flags got=%b exp=0000", {busy, done, pass, vif.in_ready});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, done, vif.in_ready} !== 3'b000) begin
      bad++; $display("FAIL idle_flags got=%b exp=000", {busy, done, vif.in_ready});
    end
  endtask

  task automatic test_add();
    clear_q();
    add_vec(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_vec(2'b00, 16'haa55, 16'h55aa, 16'hffff, 1'b0);
    add_vec(2'b00, 16'hffff, 16'h0001, 16'h0000, 1'b1);
    add_vec(2'b00, 16'h0001, 16'h7fff, 16'h8000, 1'b0);
    drive_run(8'd4, 1'b0);
    total++; if (pass_cnt !== 8'd4) begin bad++; $display("FAIL add_pass_cnt got=%0d exp=4", pass_cnt); end
    total++; if (fail_cnt !== 8'd0) begin bad++; $display("FAIL add_fail_cnt got=%0d exp=0", fail_cnt); end
    total++; if ({done, pass, busy} !== 3'b110) begin
      bad++; $display("FAIL add_flags got=%b exp=110", {done, pass, busy});
    end
    total++; if (m_pass != 4) begin bad++; $display("FAIL add_model got=%0d exp=4", m_pass); end
  endtask

  task automatic test_sub_logic();
    clear_q();
    add_vec(2'b01, 16'hffff, 16'h0001, 16'hfffe, 1'b1);
    add_vec(2'b01, 16'h0001, 16'h7fff, 16'h8002, 1'b0);
    add_vec(2'b10, 16'haa55, 16'h55aa, 16'h0000, 1'b0);
    add_vec(2'b11, 16'haa55, 16'h55aa, 16'hffff, 1'b0);
    drive_run(8'd4, 1'b1);
    total++; if (pass_cnt !== 8'd4) begin bad++; $display("FAIL sl_pass_cnt got=%0d exp=4", pass_cnt); end
    total++; if ({fail_cnt, pass} !== {8'd0, 1'b1}) begin
      bad++; $display("FAIL sl_pass got=%0d/%b exp=0/1", fail_cnt, pass);
    end
  endtask

  task automatic test_inject_fail();
    clear_q();
    add_vec(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_vec(2'b00, 16'haa55, 16'h55aa, 16'hffff, 1'b0);
    add_vec(2'b00, 16'hffff, 16'h0001, 16'h0000, 1'b0);
    add_vec(2'b00, 16'h0001, 16'h7fff, 16'h0000, 1'b0);
    drive_run(8'd4, 1'b0);
    total++; if (first_fail_idx !== 8'd2) begin bad++; $display("FAIL inj_idx got=%0d exp=2", first_fail_idx); end
    total++; if (first_fail_exp !== 17'h10000) begin
      bad++; $display("FAIL inj_exp got=%h exp=10000", first_fail_exp);
    end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL inj_pass got=%b exp=0", pass); end
    total++; if (fail_cnt !== 8'(m_fail)) begin bad++; $display("FAIL inj_fail_cnt got=%0d exp=%0d", fail_cnt, m_fail); end
    total++; if (pass_cnt !== 8'(m_pass)) begin bad++; $display("FAIL inj_pass_cnt got=%0d exp=%0d", pass_cnt, m_pass); end
  endtask

  task automatic test_stream();
    int          n_acc, t;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [16:0] r;
    n_acc = 0;
    start = 1'b1; num_vecs = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_vec(1'b0, op, a, b, r);
      vif.in_valid = 1'b1; vif.in_op = op; vif.in_i0 = a; vif.in_i1 = b;
      vif.in_o = r[15:0]; vif.in_cout = r[16];
      @(negedge clk);
      if (vif.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    vif.in_valid = 1'b0;
    total++; if (n_acc != 3) begin bad++; $display("FAIL stream_accepts got=%0d exp=3", n_acc); end
    total++; if (vif.in_ready !== 1'b0) begin bad++; $display("FAIL stream_ready got=%b exp=0", vif.in_ready); end
    t = 0;
    while (!done && t < 20) begin @(posedge clk); #1; t++; end
    total++; if ({done, pass} !== 2'b11) begin bad++; $display("FAIL stream_done got=%b exp=11", {done, pass}); end
    total++; if (pass_cnt !== 8'd3) begin bad++; $display("FAIL stream_pass_cnt got=%0d exp=3", pass_cnt); end
  endtask

  task automatic test_reset_midrun();
    int          n_acc, t;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [16:0] r;
    start = 1'b1; num_vecs = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_vec(1'b0, op, a, b, r);
      vif.in_valid = 1'b1; vif.in_op = op; vif.in_i0 = a; vif.in_i1 = b;
      vif.in_o = r[15:0]; vif.in_cout = r[16];
      @(posedge clk); #1;
    end
    rst_n = 1'b0; vif.in_valid = 1'b0;
    #1;
    total++; if ({pass_cnt, fail_cnt} !== 16'd0) begin
      bad++; $display("FAIL midrst_cnts got=%0d/%0d exp=0/0", pass_cnt, fail_cnt);
    end
    total++; if ({vif.in_ready, busy, done} !== 3'b000) begin
      bad++; $display("FAIL midrst_flags got=%b exp=000", {vif.in_ready, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_acc = 0;
    start = 1'b1; num_vecs = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_vec(1'b0, op, a, b, r);
      vif.in_valid = 1'b1; vif.in_op = op; vif.in_i0 = a; vif.in_i1 = b;
      vif.in_o = r[15:0]; vif.in_cout = r[16];
      @(negedge clk);
      if (vif.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    vif.in_valid = 1'b0;
    t = 0;
    while (!done && t < 20) begin @(posedge clk); #1; t++; end
    total++; if (n_acc != 1) begin bad++; $display("FAIL nv0_accepts got=%0d exp=1", n_acc); end
    total++; if ({done, pass_cnt} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL nv0_result got=%b/%0d exp=1/1", done, pass_cnt);
    end
  endtask

  task automatic test_random();
    int          nv, eff;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [16:0] r;
    for (int run = 0; run < 8; run++) begin
      nv  = $urandom_range(0, 14);
      eff = (nv == 0) ? 1 : nv;
      clear_q();
      for (int i = 0; i < eff; i++) begin
        rand_vec(1'b1, op, a, b, r);
        add_vec(op, a, b, r[15:0], r[16]);
      end
      drive_run(8'(nv), 1'b1);
      total++; if (pass_cnt !== 8'(m_pass)) begin bad++; $display("FAIL rnd_pass_cnt run=%0d got=%0d exp=%0d", run, pass_cnt, m_pass); end
      total++; if (fail_cnt !== 8'(m_fail)) begin bad++; $display("FAIL rnd_fail_cnt run=%0d got=%0d exp=%0d", run, fail_cnt, m_fail); end
      total++; if (first_fail_idx !== 8'(m_idx)) begin bad++; $display("FAIL rnd_ff_idx run=%0d got=%0d exp=%0d", run, first_fail_idx, m_idx); end
      total++; if (first_fail_exp !== m_exp) begin bad++; $display("FAIL rnd_ff_exp run=%0d got=%h exp=%h", run, first_fail_exp, m_exp); end
      total++; if (pass !== (m_fail == 0)) begin bad++; $display("FAIL rnd_pass run=%0d got=%b exp=%b", run, pass, m_fail == 0); end
`ifndef ALU_CHK_HALT_ON_FAIL_EN
      total++; if (m_acc != eff) begin bad++; $display("FAIL rnd_accepts run=%0d got=%0d exp=%0d", run, m_acc, eff); end
`endif
    end
  endtask

`ifdef ALU_CHK_HALT_ON_FAIL_EN
  task automatic test_halt();
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [16:0] r;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      rand_vec(1'b0, op, a, b, r);
      if (i == 1) r = r ^ 17'h00001;
      add_vec(op, a, b, r[15:0], r[16]);
    end
    drive_run(8'd8, 1'b0);
    total++; if (int'(pass_cnt) + int'(fail_cnt) > 3) begin
      bad++; $display("FAIL halt_count got=%0d exp=<=3", int'(pass_cnt) + int'(fail_cnt));
    end
    total++; if (first_fail_idx !== 8'd1) begin bad++; $display("FAIL halt_idx got=%0d exp=1", first_fail_idx); end
    total++; if ({done, pass} !== 2'b10) begin bad++; $display("FAIL halt_flags got=%b exp=10", {done, pass}); end
    total++; if (m_acc >= 8) begin bad++; $display("FAIL halt_accepts got=%0d exp=<8", m_acc); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; num_vecs = '0;
    vif.in_valid = 1'b0; vif.in_op = '0; vif.in_i0 = '0; vif.in_i1 = '0;
    vif.in_o = '0; vif.in_cout = 1'b0;
    test_reset();
    test_add();
    test_sub_logic();
    test_inject_fail();
    test_stream();
    test_reset_midrun();
    test_random();
`ifdef ALU_CHK_HALT_ON_FAIL_EN
    test_halt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Receiving end of the ALU stimulus interface: consumes issued {op, i0, i1} vectors together with the ALU's observed {o, cout}.
- Recomputes the expected result in an internal reference model and compares it against the observed result.
- Keeps pass/fail counts and captures the first mismatching vector.
- Sits beside the 16-bit alu instance; reports done/pass to the top level after a programmed number of vectors.

Parameters:
- W, 16, operand/result width.
- CNT_W, 8, width of the vector, pass and fail counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run.
- num_vecs  in  CNT_W  vectors expected this run; sampled on start; 0 is treated as 1.
- in_valid  in  1  vector/result present.
- in_ready  out  1  checker can accept.
- in_op  in  2  ALU op code.
- in_i0  in  W  operand 0.
- in_i1  in  W  operand 1.
- in_o  in  W  observed ALU result.
- in_cout  in  1  observed ALU carry.
- pass_cnt  out  CNT_W  matching vectors.
- fail_cnt  out  CNT_W  mismatching vectors.
- first_fail_idx  out  CNT_W  index of first mismatch.
- first_fail_exp  out  W+1  expected {cout, o} of first mismatch.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  done && fail_cnt==0.

Behaviour:
- Reset (reset=0, asynchronous) forces every output, counter, capture register and pipeline valid to 0; state goes to IDLE.
- FSM states:
  - IDLE: in_ready=0. start → RUN; clears counters and captures; latches num_vecs (0 is loaded as 1); clears done.
  - RUN: in_ready=1. A transfer occurs on any cycle with in_valid && in_ready. When accepted count == latched num_vecs, in_ready drops the cycle after the last transfer and the state goes to DRAIN.
  - DRAIN: in_ready=0. Waits until both pipeline stages are empty → DONE.
  - DONE: done=1; busy=0. start → RUN, same as from IDLE.
  - busy=1 in RUN and DRAIN.
- start while in RUN/DRAIN is ignored.
- Pipeline:
  - Stage 1 registers the transfer plus its index (0-based accept count).
  - Stage 2 computes expected {cout, o} and compares.
  - Counters and captures update at the end of stage 2, so latency is 2 cycles from transfer to counter update.
  - One transfer per cycle is sustained.
- Reference model, with all arithmetic W+1 bits wide:
  - op 00 ADD: {c, r} = i0 + i1.
  - op 01 SUB: {c, r} = i0 + ~i1 + 1; c=1 means no borrow.
  - op 10 AND: r = i0 & i1, c = 0.
  - op 11 OR: r = i0 | i1, c = 0.
- Compare: pass when {in_cout, in_o} == expected; otherwise fail.
- First mismatch: only the first one in a run loads first_fail_idx/first_fail_exp; later mismatches leave them unchanged.
- Counter saturation: pass_cnt and fail_cnt saturate at all-ones and never wrap. The accept counter cannot exceed num_vecs.
- Reset mid-run aborts immediately: state IDLE, all counts 0, done=0, pipeline flushed.
- in_valid while in_ready=0 is not a transfer; inputs are not sampled.

Optional Feature:
- Macro ALU_CHK_HALT_ON_FAIL_EN.
- Defined: the first mismatch at stage 2 moves the FSM to DRAIN at once. in_ready drops the next cycle, and any vector already in stage 1 is still checked and counted. done asserts with pass=0 and the accept count below num_vecs.
- Undefined: the run always consumes num_vecs vectors regardless of mismatches.

Test Plan:
- Reset, then start with num_vecs=4 and four correct ADD vectors: (0000,0000)→0000/0; (aa55,55aa)→ffff/0; (ffff,0001)→0000/1; (0001,7fff)→8000/0. Expect pass_cnt=4, fail_cnt=0, done=1, pass=1.
- SUB/AND/OR correct set: SUB (ffff,0001)→fffe/1; SUB (0001,7fff)→8002/0; AND (aa55,55aa)→0000/0; OR (aa55,55aa)→ffff/0. Expect pass=1.
- Inject a bad result on vector 2 (ADD ffff+0001 reported as 0000/0). Expect fail_cnt=1, first_fail_idx=2, first_fail_exp=1_0000, pass=0. Then a second bad vector at index 3: first_fail_idx stays 2.
- in_valid held high for 6 cycles with num_vecs=3: exactly 3 accepted, in_ready low afterward, done exactly 2 cycles after the last pipeline stage empties.
- Assert reset low mid-run after 2 transfers: counts go to 0 immediately and in_ready=0. A new start with num_vecs=0 accepts exactly 1 vector.
- With ALU_CHK_HALT_ON_FAIL_EN defined, a mismatch at index 1 of 8: done asserts with pass_cnt+fail_cnt ≤ 3 and first_fail_idx=1.
